// File: rtl/ddr_req_arbiter.sv
// ============================================================================
// Module   : ddr_req_arbiter
// Purpose  : Shares the DDR2 memory-manager command port between a read
//            requester and a write requester. Traffic is held off until
//            memory_init_done. Reads have priority, and a starvation counter
//            forces a write after STARVE_LIMIT reads. A watchdog flags hung
//            commands.
// Options  : ARB_STATS_EN adds completed-command counters and a worst-case
//            vld-to-done latency output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_req_arbiter #(
   parameter int ADDR_W       = 25,
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT      = 1023
) (
   input  logic              mem_clk_s,
   input  logic              mem_rst_s_n,
   input  logic              memory_init_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_done,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_gnt,
   output logic              wr_done,
   output logic              mem_cmd_vld,
   output logic              mem_cmd_rw,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   input  logic              mem_cmd_ack,
   input  logic              mem_cmd_done,
   output logic              arb_timeout
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt,
   output logic [9:0]        max_lat
`endif
);

   // Starvation counter is wide enough to actually reach STARVE_LIMIT.
   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam int              WD_W       = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0]   STARVE_SAT = '1;
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_WAIT_INIT = 2'd0,
      S_IDLE      = 2'd1,
      S_ISSUE     = 2'd2,
      S_BUSY      = 2'd3
   } state_t;

   state_t            state_q;
   logic              rd_gnt_q, wr_gnt_q, rd_done_q, wr_done_q;
   logic              vld_q, rw_q, timeout_q;
   logic [ADDR_W-1:0] addr_q;
   logic [SW-1:0]     starve_q;
   logic [WD_W-1:0]   wd_q;
   logic              pick_wr;

   // Write wins when reads are absent or the write has waited long enough.
   assign pick_wr = wr_req && (!rd_req || (starve_q >= STARVE_MAX));

   // Main arbitration FSM; every output is registered.
   always_ff @(posedge mem_clk_s or negedge mem_rst_s_n) begin
      if (!mem_rst_s_n) begin
         state_q   <= S_WAIT_INIT;
         rd_gnt_q  <= 1'b0;
         wr_gnt_q  <= 1'b0;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
         vld_q     <= 1'b0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         timeout_q <= 1'b0;
         starve_q  <= '0;
         wd_q      <= '0;
      end else begin
         rd_gnt_q  <= 1'b0;
         wr_gnt_q  <= 1'b0;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
         if (!memory_init_done) begin
            // Memory lost its init: abandon any command, keep starvation history.
            state_q <= S_WAIT_INIT;
            vld_q   <= 1'b0;
            wd_q    <= '0;
         end else begin
            case (state_q)
               S_WAIT_INIT: state_q <= S_IDLE;
               S_IDLE: begin
                  wd_q <= '0;
                  if (pick_wr) begin
                     vld_q   <= 1'b1;
                     rw_q    <= 1'b0;
                     addr_q  <= wr_addr;
                     state_q <= S_ISSUE;
                  end else if (rd_req) begin
                     vld_q   <= 1'b1;
                     rw_q    <= 1'b1;
                     addr_q  <= rd_addr;
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (mem_cmd_ack) begin
                     vld_q <= 1'b0;
                     if (rw_q) begin
                        rd_gnt_q <= 1'b1;
                        if (wr_req && (starve_q != STARVE_SAT))
                           starve_q <= starve_q + 1'b1;
                     end else begin
                        wr_gnt_q <= 1'b1;
                        starve_q <= '0;
                     end
                     if (mem_cmd_done) begin
                        rd_done_q <= rw_q;
                        wr_done_q <= !rw_q;
                        state_q   <= S_IDLE;
                     end else begin
                        wd_q    <= wd_q + 1'b1;
                        state_q <= S_BUSY;
                     end
                  end else if (wd_q >= WD_LAST) begin
                     vld_q     <= 1'b0;
                     timeout_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
               S_BUSY: begin
                  if (mem_cmd_done) begin
                     rd_done_q <= rw_q;
                     wr_done_q <= !rw_q;
                     state_q   <= S_IDLE;
                  end else if (wd_q >= WD_LAST) begin
                     timeout_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
               default: state_q <= S_WAIT_INIT;
            endcase
         end
      end
   end

   assign rd_gnt       = rd_gnt_q;
   assign wr_gnt       = wr_gnt_q;
   assign rd_done      = rd_done_q;
   assign wr_done      = wr_done_q;
   assign mem_cmd_vld  = vld_q;
   assign mem_cmd_rw   = rw_q;
   assign mem_cmd_addr = addr_q;
   assign arb_timeout  = timeout_q;

`ifdef ARB_STATS_EN
   localparam logic [WD_W:0] LAT_CAP = (WD_W + 1)'(1023);

   logic [15:0]   rd_cnt_q, wr_cnt_q;
   logic [9:0]    max_lat_q;
   logic [WD_W:0] lat;
   logic [9:0]    lat_sat;
   logic          fin;

   // A command finishes on the cycle its done pulse is being registered.
   assign fin     = memory_init_done &&
                    (((state_q == S_ISSUE) && mem_cmd_ack && mem_cmd_done) ||
                     ((state_q == S_BUSY) && mem_cmd_done));
   assign lat     = {1'b0, wd_q} + (WD_W + 1)'(1);
   assign lat_sat = (lat > LAT_CAP) ? 10'h3FF : 10'(lat);

   // Completed-command counters and worst observed latency.
   always_ff @(posedge mem_clk_s or negedge mem_rst_s_n) begin
      if (!mem_rst_s_n) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         max_lat_q <= '0;
      end else if (fin) begin
         if (rw_q) rd_cnt_q <= rd_cnt_q + 16'd1;
         else      wr_cnt_q <= wr_cnt_q + 16'd1;
         if (lat_sat > max_lat_q) max_lat_q <= lat_sat;
      end
   end

   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign max_lat = max_lat_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
// ============================================================================
// Module   : tb_ddr_req_arbiter
// Purpose  : Self-checking bench for ddr_req_arbiter. A transaction-level
//            model predicts which requester is picked, grant and done pulses,
//            and the sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_req_arbiter;
   localparam int ADDR_W       = 25;
   localparam int STARVE_LIMIT = 8;
   localparam int TIMEOUT      = 1023;

   logic              clk = 1'b0, rst_n = 1'b0, init = 1'b0;
   logic              rd_req = 1'b0, wr_req = 1'b0, ack = 1'b0, done = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0, wr_addr = '0;
   logic              rd_gnt, rd_done, wr_gnt, wr_done, vld, rw, tmo;
   logic [ADDR_W-1:0] cmd_addr;
`ifdef ARB_STATS_EN
   logic [15:0]       rd_cnt, wr_cnt;
   logic [9:0]        max_lat;
   logic [15:0]       rd_cnt_snap;
`endif

   int vectors = 0, miscompares = 0;

   // reference model state
   int  m_starve = 0;
   bit  m_busy = 0, m_rw = 0, m_to = 0, mon_en = 0;
   int  n_gnt = 0, n_done = 0;

   // inputs/outputs as they were during the cycle before the last edge
   bit                s_init, s_rd_req, s_wr_req, s_ack, s_done, p_vld;
   logic [ADDR_W-1:0] s_rd_addr, s_wr_addr;

   ddr_req_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .mem_clk_s        (clk),
      .mem_rst_s_n      (rst_n),
      .memory_init_done (init),
      .rd_req           (rd_req),
      .rd_addr          (rd_addr),
      .rd_gnt           (rd_gnt),
      .rd_done          (rd_done),
      .wr_req           (wr_req),
      .wr_addr          (wr_addr),
      .wr_gnt           (wr_gnt),
      .wr_done          (wr_done),
      .mem_cmd_vld      (vld),
      .mem_cmd_rw       (rw),
      .mem_cmd_addr     (cmd_addr),
      .mem_cmd_ack      (ack),
      .mem_cmd_done     (done),
      .arb_timeout      (tmo)
`ifdef ARB_STATS_EN
      ,
      .rd_cnt           (rd_cnt),
      .wr_cnt           (wr_cnt),
      .max_lat          (max_lat)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction-level expectations for the cycle that just finished.
   task automatic monitor();
      bit exp_gnt, exp_done, pick_w;
      if (mon_en) begin
         if (vld && !p_vld) begin
            pick_w = s_wr_req && (!s_rd_req || m_starve >= STARVE_LIMIT);
            chk("cmd_rw", 32'(rw), 32'(!pick_w));
            chk("cmd_addr", 32'(cmd_addr), 32'(pick_w ? s_wr_addr : s_rd_addr));
            m_rw = !pick_w;
         end
         exp_gnt  = p_vld && s_ack && s_init;
         exp_done = s_init && s_done && (m_busy || exp_gnt);
         chk("rd_gnt", 32'(rd_gnt), 32'(exp_gnt && m_rw));
         chk("wr_gnt", 32'(wr_gnt), 32'(exp_gnt && !m_rw));
         chk("rd_done", 32'(rd_done), 32'(exp_done && m_rw));
         chk("wr_done", 32'(wr_done), 32'(exp_done && !m_rw));
         chk("arb_timeout", 32'(tmo), 32'(m_to));
         if (exp_gnt) begin
            n_gnt++;
            if (m_rw) begin
               if (s_wr_req) m_starve++;
            end else begin
               m_starve = 0;
            end
         end
         if (exp_done) n_done++;
         if (exp_gnt) m_busy = !exp_done;
         else         m_busy = m_busy && s_init && !exp_done;
      end
   endtask

   task automatic tick();
      s_init    = init;    s_rd_req  = rd_req;  s_wr_req = wr_req;
      s_ack     = ack;     s_done    = done;    p_vld    = vld;
      s_rd_addr = rd_addr; s_wr_addr = wr_addr;
      @(posedge clk);
      #1;
      monitor();
   endtask

   initial begin
      int g, vcnt, d0, g0, cyc;

      // ---- reset: outputs low immediately, before any clock edge
      #1;
      chk("rst_vld", 32'(vld), 0);
      chk("rst_rw", 32'(rw), 0);
      chk("rst_addr", 32'(cmd_addr), 0);
      chk("rst_pulses", 32'({rd_gnt, wr_gnt, rd_done, wr_done}), 0);
      chk("rst_timeout", 32'(tmo), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1;

      // ---- 1: requests ignored while init low, then 2-cycle issue latency
      rd_req = 1; wr_req = 1; rd_addr = 25'h0000111; wr_addr = 25'h0000222;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("noinit_vld", 32'(vld), 0);
      end
      rd_req = 0; wr_req = 0;
      tick();
      rd_req = 1; rd_addr = 25'h0ABCDEF; init = 1;
      tick();
      chk("init_lat1_vld", 32'(vld), 0);
      tick();
      chk("init_lat2_vld", 32'(vld), 1);
      ack = 1;
      tick();
      ack = 0; rd_req = 0; done = 1;
      tick();
      done = 0;
      tick();

      // ---- 2: read, ack after 3 cycles, done after 5 more
      rd_req = 1; rd_addr = 25'h0001234;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (vld) vcnt++;
      end
      chk("t2_rw", 32'(rw), 1);
      chk("t2_addr", 32'(cmd_addr), 32'h0001234);
      ack = 1;
      tick();
      chk("t2_vld_cycles", 32'(vcnt), 4);
      chk("t2_gnt", 32'(rd_gnt), 1);
      chk("t2_vld_drop", 32'(vld), 0);
      ack = 0; rd_req = 0;
      repeat (4) tick();
      done = 1;
      tick();
      chk("t2_done", 32'(rd_done), 1);
      done = 0;
      tick();
      chk("t2_done_single", 32'(rd_done), 0);

      // ---- 3: both requesters held, immediate completion: 8 reads then 1 write
      rd_req = 1; wr_req = 1; rd_addr = 25'h1000001; wr_addr = 25'h0F0F0F0;
      ack = 1; done = 1; g = 0;
      for (int c = 0; c < 400 && g < 18; c++) begin
         tick();
         if (rd_gnt || wr_gnt) begin
            chk($sformatf("t3_grant%0d_is_wr", g), 32'(wr_gnt), 32'((g % 9) == 8));
            g++;
         end
      end
      rd_req = 0; wr_req = 0; ack = 0; done = 0;
      chk("t3_grant_count", 32'(g), 18);
      tick();

      // ---- 4: same-cycle ack and done
      rd_req = 1; rd_addr = 25'h0000444;
      tick();
      ack = 1; done = 1;
      tick();
      chk("t4_gnt", 32'(rd_gnt), 1);
      chk("t4_done", 32'(rd_done), 1);
      ack = 0; done = 0; rd_req = 0;
      tick();
      chk("t4_idle_vld", 32'(vld), 0);
      rd_req = 1; rd_addr = 25'h0000555;
      tick();
      chk("t4_next_vld", 32'(vld), 1);
      ack = 1; done = 1;
      tick();
      ack = 0; done = 0; rd_req = 0;
      tick();

      // ---- 6: init drops during BUSY: no done pulse
      rd_req = 1; rd_addr = 25'h0000666;
      tick();
      ack = 1;
      tick();
      chk("t6_gnt", 32'(rd_gnt), 1);
`ifdef ARB_STATS_EN
      rd_cnt_snap = rd_cnt;
`endif
      ack = 0; rd_req = 0;
      tick();
      init = 0; done = 1;
      tick();
      chk("t6_no_done", 32'(rd_done), 0);
      chk("t6_vld", 32'(vld), 0);
      init = 1; done = 0;
      repeat (2) tick();
      chk("t6_still_no_done", 32'(rd_done), 0);
`ifdef ARB_STATS_EN
      chk("t6_rd_cnt", 32'(rd_cnt), 32'(rd_cnt_snap));
`endif

      // ---- 5: never acknowledged -> timeout after TIMEOUT cycles of vld
      rd_req = 1; rd_addr = 25'h1FFFFFF;
      tick();
      chk("t5_vld_rise", 32'(vld), 1);
      for (int i = 1; i < TIMEOUT; i++) tick();
      chk("t5_vld_last", 32'(vld), 1);
      m_to = 1;
      tick();
      chk("t5_vld_drop", 32'(vld), 0);
      chk("t5_timeout", 32'(tmo), 1);
      tick();
      chk("t5_reissue", 32'(vld), 1);
      ack = 1; done = 1;
      tick();
      chk("t5_served", 32'(rd_gnt), 1);
      ack = 0; done = 0; rd_req = 0;
      tick();

      // ---- randomized traffic against the model
      d0 = n_done; g0 = n_gnt; cyc = 0;
      while (cyc < 20000 && (n_done - d0) < 150) begin
         tick();
         cyc++;
         if (rd_req && rd_gnt) rd_req = 0;
         else if (!rd_req && $urandom_range(0, 3) != 0) begin
            rd_req = 1; rd_addr = ADDR_W'($urandom);
         end
         if (wr_req && wr_gnt) wr_req = 0;
         else if (!wr_req && $urandom_range(0, 1) == 0) begin
            wr_req = 1; wr_addr = ADDR_W'($urandom);
         end
         if (vld) begin
            ack  = ($urandom_range(0, 2) == 0);
            done = ack && ($urandom_range(0, 1) == 0);
         end else if (m_busy) begin
            ack  = 0;
            done = ($urandom_range(0, 2) == 0);
         end else begin
            ack = 0; done = 0;
         end
      end
      chk("rand_completed", 32'(n_done - d0), 150);
      chk("rand_gnt_eq_done", 32'(n_gnt - g0), 32'(n_done - d0));
      rd_req = 0; wr_req = 0; ack = 0; done = 0;

      // ---- async reset mid-command clears outputs at once
      rd_req = 1; rd_addr = 25'h0000777;
      repeat (3) tick();
      chk("ar_vld_before", 32'(vld), 1);
      mon_en = 0;
      #2 rst_n = 0;
      #1;
      chk("ar_vld", 32'(vld), 0);
      chk("ar_timeout", 32'(tmo), 0);
      chk("ar_rw", 32'(rw), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
